// File: rtl/gray_ptr_fifo.sv
// rtl/gray_ptr_fifo.sv - single-clock FIFO with binary pointers exported as Gray code
// Optional almostFull/almostEmpty outputs are enabled by defining FIFO_ALMOST_FLAGS_EN.
module gray_ptr_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              wrEn,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   wrPtrGray,
  output logic [ADDR_W:0]   rdPtrGray,
  input  logic              clrErr,
`ifdef FIFO_ALMOST_FLAGS_EN
  output logic              almostFull,
  output logic              almostEmpty,
`endif
  output logic              overflow,
  output logic              underflow
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     wr_nxt, rd_nxt, cnt_nxt;
  logic              push_acc, pop_acc;

  // A pop at full frees a slot in the same cycle, so the push is still taken.
  always_comb begin
    push_acc = wrEn & (~full | rdEn);
    pop_acc  = rdEn & ~empty;
    wr_nxt   = wr_ptr + PW'(push_acc);
    rd_nxt   = rd_ptr + PW'(pop_acc);
    cnt_nxt  = count + PW'(push_acc) - PW'(pop_acc);
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr[ADDR_W-1:0]] <= wrData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wrPtrGray <= '0;
      rdPtrGray <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      rdData    <= '0;
      rdValid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      wrPtrGray <= wr_nxt ^ (wr_nxt >> 1);
      rdPtrGray <= rd_nxt ^ (rd_nxt >> 1);
      count     <= cnt_nxt;
      full      <= (cnt_nxt == PW'(DEPTH));
      empty     <= (cnt_nxt == '0);
      rdValid   <= pop_acc;
      if (pop_acc) rdData <= mem[rd_ptr[ADDR_W-1:0]];
      // A fresh error in the clearing cycle keeps its flag set.
      overflow  <= (overflow  & ~clrErr) | (wrEn & ~push_acc);
      underflow <= (underflow & ~clrErr) | (rdEn & ~pop_acc);
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
    end else begin
      almostFull  <= (int'(cnt_nxt) >= AF_LEVEL);
      almostEmpty <= (int'(cnt_nxt) <= AE_LEVEL);
    end
  end
`endif

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// tb/tb_gray_ptr_fifo.sv - directed scoreboard bench for gray_ptr_fifo
module tb_gray_ptr_fifo;

  logic       clk = 1'b0;
  logic       rstN, wrEn, rdEn, clrErr;
  logic [7:0] wrData, rdData;
  logic       rdValid, full, empty, overflow, underflow;
  logic [3:0] count, wrPtrGray, rdPtrGray;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic       almostFull, almostEmpty;
`endif

  always #5 clk = ~clk;

  gray_ptr_fifo dut (
    .clk(clk), .rstN(rstN), .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn),
    .rdData(rdData), .rdValid(rdValid), .full(full), .empty(empty), .count(count),
    .wrPtrGray(wrPtrGray), .rdPtrGray(rdPtrGray), .clrErr(clrErr),
`ifdef FIFO_ALMOST_FLAGS_EN
    .almostFull(almostFull), .almostEmpty(almostEmpty),
`endif
    .overflow(overflow), .underflow(underflow)
  );

  int         tests = 0;
  int         fails = 0;
  int         mcount;
  logic       movf, munf;
  logic [3:0] mwp, mrp, wg_prev, rg_prev;
  logic [7:0] mq[$];
  logic [7:0] expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mcount = 0; movf = 0; munf = 0; mwp = 0; mrp = 0; wg_prev = 0; rg_prev = 0;
    mq.delete(); expq.delete();
  endtask

  task automatic chk_reset_outputs(input string ph);
    chk({ph, "_count"}, count, 0);
    chk({ph, "_empty"}, empty, 1);
    chk({ph, "_full"}, full, 0);
    chk({ph, "_rddata"}, rdData, 0);
    chk({ph, "_rdvalid"}, rdValid, 0);
    chk({ph, "_ovf"}, overflow, 0);
    chk({ph, "_unf"}, underflow, 0);
    chk({ph, "_wgray"}, wrPtrGray, 0);
    chk({ph, "_rgray"}, rdPtrGray, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
    chk({ph, "_afull"}, almostFull, 0);
    chk({ph, "_aempty"}, almostEmpty, 1);
`endif
  endtask

  // One clock of stimulus; the model predicts, then outputs are sampled 1ns after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic pa, qa;
    wrEn = w; wrData = d; rdEn = r; clrErr = c;
    pa = w && (mcount < 8 || r);
    qa = r && (mcount > 0);
    if (qa) expq.push_back(mq.pop_front());
    if (pa) mq.push_back(d);
    mcount = mcount + int'(pa) - int'(qa);
    movf = (movf && !c) || (w && !pa);
    munf = (munf && !c) || (r && !qa);
    if (pa) mwp = mwp + 4'd1;
    if (qa) mrp = mrp + 4'd1;
    @(posedge clk); #1;
    chk("count", count, mcount);
    chk("full", full, mcount == 8);
    chk("empty", empty, mcount == 0);
    chk("rdvalid", rdValid, qa);
    chk("overflow", overflow, movf);
    chk("underflow", underflow, munf);
    chk("wr_gray", wrPtrGray, mwp ^ (mwp >> 1));
    chk("rd_gray", rdPtrGray, mrp ^ (mrp >> 1));
    if (wrPtrGray !== wg_prev) chk("wr_gray_onebit", $countones(wrPtrGray ^ wg_prev), 1);
    if (rdPtrGray !== rg_prev) chk("rd_gray_onebit", $countones(rdPtrGray ^ rg_prev), 1);
    wg_prev = wrPtrGray; rg_prev = rdPtrGray;
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("almost_full", almostFull, mcount >= 6);
    chk("almost_empty", almostEmpty, mcount <= 2);
`endif
    if (rdValid === 1'b1) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $error("FAIL sb_unexpected: observed %0h expected none", rdData);
      end else chk("rddata", rdData, expq.pop_front());
    end
    wrEn = 0; rdEn = 0; clrErr = 0;
  endtask

  initial begin
    rstN = 0; wrEn = 0; rdEn = 0; clrErr = 0; wrData = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstN = 1;

    for (int i = 0; i < 8; i++) step(1, 8'h11 + 8'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);

    for (int i = 0; i < 8; i++) step(1, 8'h21 + 8'(i), 0, 0);
    step(1, 8'hAA, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    for (int i = 0; i < 8; i++) step(1, 8'h31 + 8'(i), 0, 0);
    step(1, 8'h3F, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    step(1, 8'h40, 1, 0);
    step(0, 8'h00, 1, 1);
    step(1, 8'h41, 0, 1);

    for (int i = 0; i < 40; i++) step(1, 8'h80 + 8'(i), 1, 0);
    for (int i = 0; i < 2; i++) step(0, 8'h00, 1, 0);

    for (int i = 0; i < 5; i++) step(1, 8'hC1 + 8'(i), 0, 0);
    rdEn = 1;
    #3 rstN = 0;
    #1;
    chk_reset_outputs("async_reset");
    rdEn = 0;
    model_reset();
    @(posedge clk); #1;
    rstN = 1;
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("post_reset_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
